// File: rtl/prog_loader.sv
// UART program loader: fills the 256x8 instruction memory from a framed image and holds the CPU
// in reset until a complete image lands. Define PROG_LOADER_CHECKSUM_EN to carry and verify CSUM.
module prog_loader #(
   parameter int         CLKS_PER_BIT = 16,
   parameter int         TIMEOUT_CLKS = 65535,
   parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   output logic       imem_we,
   output logic [7:0] imem_addr,
   output logic [7:0] imem_wdata,
   output logic       cpu_hold,
   output logic       busy,
   output logic       load_done,
   output logic       load_error
);
   localparam int            CW      = $clog2(CLKS_PER_BIT);
   localparam int            TW      = $clog2(TIMEOUT_CLKS + 1);
   localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
   localparam logic [TW-1:0] TMO_M1  = TW'(TIMEOUT_CLKS - 1);

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_st_t;
   typedef enum logic [1:0] {L_IDLE, L_LEN, L_DATA, L_CSUM} ld_st_t;

   rx_st_t        rx_st;
   logic          rx_meta, rx_s, rx_d;
   logic [CW-1:0] bit_cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shreg;
   logic          byte_valid, frame_err;

   // rx_d lags rx_s by one clock so the start is a true falling edge, not a held-low line
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_meta    <= 1'b1;
         rx_s       <= 1'b1;
         rx_d       <= 1'b1;
         rx_st      <= RX_IDLE;
         bit_cnt    <= '0;
         bit_idx    <= '0;
         shreg      <= '0;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         rx_meta    <= rx;
         rx_s       <= rx_meta;
         rx_d       <= rx_s;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
         case (rx_st)
            RX_IDLE: if (rx_d && !rx_s) begin
               rx_st   <= RX_START;
               bit_cnt <= '0;
            end
            RX_START: if (bit_cnt == HALF_M1) begin
               bit_cnt <= '0;
               bit_idx <= '0;
               rx_st   <= rx_s ? RX_IDLE : RX_DATA;
            end else bit_cnt <= bit_cnt + 1'b1;
            RX_DATA: if (bit_cnt == FULL_M1) begin
               bit_cnt <= '0;
               shreg   <= {rx_s, shreg[7:1]};
               bit_idx <= bit_idx + 1'b1;
               if (bit_idx == 3'd7) rx_st <= RX_STOP;
            end else bit_cnt <= bit_cnt + 1'b1;
            default: if (bit_cnt == FULL_M1) begin
               bit_cnt    <= '0;
               byte_valid <= rx_s;
               frame_err  <= !rx_s;
               rx_st      <= RX_IDLE;
            end else bit_cnt <= bit_cnt + 1'b1;
         endcase
      end
   end

   ld_st_t        st, st_nx;
   logic [8:0]    rem;
   logic [7:0]    ptr;
   logic [TW-1:0] tmo_cnt;
   logic          timeout;
   logic          sync_hit, len_hit, wr_hit, last_hit, ok_hit, err_hit;
`ifdef PROG_LOADER_CHECKSUM_EN
   logic [7:0]    sum;
`endif

   assign timeout = (st != L_IDLE) && !byte_valid && (tmo_cnt == TMO_M1);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         st   <= L_IDLE;
         busy <= 1'b0;
      end else begin
         st   <= st_nx;
         busy <= (st_nx != L_IDLE);
      end
   end

   always_comb begin
      st_nx = st;
      case (st)
         L_IDLE: if (sync_hit) st_nx = L_LEN;
         L_LEN:  if (len_hit) st_nx = L_DATA;
`ifdef PROG_LOADER_CHECKSUM_EN
         L_DATA: if (last_hit) st_nx = L_CSUM;
         L_CSUM: if (byte_valid) st_nx = L_IDLE;
`else
         L_DATA: if (last_hit) st_nx = L_IDLE;
`endif
         default: st_nx = L_IDLE;
      endcase
      if (st != L_IDLE && (frame_err || timeout)) st_nx = L_IDLE;
   end

   always_comb begin
      sync_hit = byte_valid && (st == L_IDLE) && (shreg == SYNC_BYTE);
      len_hit  = byte_valid && (st == L_LEN);
      wr_hit   = byte_valid && (st == L_DATA);
      last_hit = wr_hit && (rem == 9'd1);
`ifdef PROG_LOADER_CHECKSUM_EN
      ok_hit   = byte_valid && (st == L_CSUM) && (shreg == sum);
      err_hit  = byte_valid && (st == L_CSUM) && (shreg != sum);
`else
      ok_hit   = last_hit;
      err_hit  = 1'b0;
`endif
      if (st != L_IDLE && (frame_err || timeout)) err_hit = 1'b1;
   end

   // LEN of 0x00 becomes 9'h100 through the zero-detect MSB
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
         cpu_hold   <= 1'b0;
         load_done  <= 1'b0;
         load_error <= 1'b0;
         rem        <= '0;
         ptr        <= '0;
         tmo_cnt    <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
         sum        <= '0;
`endif
      end else begin
         imem_we   <= wr_hit;
         load_done <= ok_hit;
         if (st == L_IDLE || byte_valid) tmo_cnt <= '0;
         else if (tmo_cnt != TMO_M1)     tmo_cnt <= tmo_cnt + 1'b1;
         if (len_hit) begin
            rem <= {shreg == 8'h00, shreg};
            ptr <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum <= '0;
`endif
         end
         if (wr_hit) begin
            imem_addr  <= ptr;
            imem_wdata <= shreg;
            ptr        <= ptr + 1'b1;
            rem        <= rem - 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum        <= sum + shreg;
`endif
         end
         if (sync_hit) begin
            cpu_hold   <= 1'b1;
            load_error <= 1'b0;
         end
         if (ok_hit)  cpu_hold   <= 1'b0;
         if (err_hit) load_error <= 1'b1;
      end
   end
endmodule
